// File: rtl/clock_pkg.sv
// Shared types and limits for the alarm clock core: hh:mm:ss record, alarm FSM states,
// and the range/12-hour helpers used by both the counter and the core.
package clock_pkg;

    localparam int HMS_W       = 6;
    localparam int MAX_HOUR    = 23;
    localparam int MAX_MIN_SEC = 59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } state_t;

    typedef struct packed {
        logic [HMS_W-1:0] hour;
        logic [HMS_W-1:0] minute;
        logic [HMS_W-1:0] second;
    } hms_t;

    function automatic logic hms_valid(input hms_t t);
        return (t.hour <= HMS_W'(MAX_HOUR)) &&
               (t.minute <= HMS_W'(MAX_MIN_SEC)) &&
               (t.second <= HMS_W'(MAX_MIN_SEC));
    endfunction

    // Midnight and noon both show as 12 on a 12-hour face.
    function automatic logic [HMS_W-1:0] hour_12h(input logic [HMS_W-1:0] h);
        logic [HMS_W-1:0] r;
        r = (h >= HMS_W'(12)) ? (h - HMS_W'(12)) : h;
        return (r == '0) ? HMS_W'(12) : r;
    endfunction

endpackage

// File: rtl/hms_counter.sv
// hh:mm:ss counter with one-second increment, range-checked load (load wins over
// increment) and a flag for an increment that lands on xx:00:00.
module hms_counter
    import clock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic load,
    input  hms_t load_val,
    output hms_t cur,
    output logic load_ok,
    output logic hour_wrap
);

    assign load_ok   = load && hms_valid(load_val);
    assign hour_wrap = inc && !load_ok &&
                       (cur.minute == HMS_W'(MAX_MIN_SEC)) &&
                       (cur.second == HMS_W'(MAX_MIN_SEC));

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else if (load_ok) begin
            cur <= load_val;
        end else if (inc) begin
            if (cur.second == HMS_W'(MAX_MIN_SEC)) begin
                cur.second <= '0;
                if (cur.minute == HMS_W'(MAX_MIN_SEC)) begin
                    cur.minute <= '0;
                    cur.hour   <= (cur.hour == HMS_W'(MAX_HOUR)) ? '0 : cur.hour + HMS_W'(1);
                end else begin
                    cur.minute <= cur.minute + HMS_W'(1);
                end
            end else begin
                cur.second <= cur.second + HMS_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_alarm_clock_core.sv
// Timekeeping core: prescaled seconds, NUM_ALARMS armed alarm slots sharing one
// ring/snooze FSM, hourly chime and 12/24-hour display mapping.
module multi_alarm_clock_core
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int NUM_ALARMS = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  CLK_50,
    input  logic                  reset_en,
    input  logic                  run_en,
    input  logic [HMS_W-1:0]      wr_hour,
    input  logic [HMS_W-1:0]      wr_minute,
    input  logic [HMS_W-1:0]      wr_second,
    input  logic                  time_wr,
    input  logic                  alarm_wr,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic                  alarm_on,
    input  logic                  snooze,
    input  logic                  dismiss,
    input  logic                  mode_12h,
    output logic [HMS_W-1:0]      clock_hour,
    output logic [HMS_W-1:0]      clock_minute,
    output logic [HMS_W-1:0]      clock_second,
    output logic [HMS_W-1:0]      disp_hour,
    output logic                  pm,
    output logic                  tick_1hz,
    output logic                  hourly_chime,
    output logic                  ringing,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output state_t                fsm_state
);

    localparam int PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [PRE_W-1:0] PRE_TERM    = PRE_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             term;
    logic             time_load_ok;
    logic             hour_wrap;
    hms_t             wr_val;
    hms_t             now;

    assign wr_val = {wr_hour, wr_minute, wr_second};
    assign term   = run_en && (pre_cnt == PRE_TERM);

    always_ff @(posedge CLK_50) begin
        if (reset_en) begin
            pre_cnt <= '0;
        end else if (time_load_ok || term) begin
            pre_cnt <= '0;
        end else if (run_en) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    hms_counter u_time (
        .clk       (CLK_50),
        .rst       (reset_en),
        .inc       (term),
        .load      (time_wr),
        .load_val  (wr_val),
        .cur       (now),
        .load_ok   (time_load_ok),
        .hour_wrap (hour_wrap)
    );

    // A write landing on the terminal count swallows that second entirely.
    always_ff @(posedge CLK_50) begin
        if (reset_en) begin
            tick_1hz     <= 1'b0;
            hourly_chime <= 1'b0;
        end else begin
            tick_1hz     <= term && !time_load_ok;
            hourly_chime <= hour_wrap;
        end
    end

    hms_t             slot_time [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] armed;
    logic             alarm_load_ok;

    assign alarm_load_ok = alarm_wr && hms_valid(wr_val);

    always_ff @(posedge CLK_50) begin
        if (reset_en) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_time[i] <= '0;
            end
            armed <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (alarm_load_ok && (alarm_idx == IDX_W'(i))) begin
                    slot_time[i] <= wr_val;
                    armed[i]     <= alarm_on;
                end
            end
        end
    end

    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    // Scan from the top so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (armed[i] && (slot_time[i] == now)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             match;
    logic             force_idle;

    assign match      = tick_1hz && hit;
    assign force_idle = alarm_load_ok && (alarm_idx == ring_idx) && (state != IDLE);

    always_ff @(posedge CLK_50) begin
        if (reset_en) begin
            state    <= IDLE;
            sec_cnt  <= '0;
            ring_idx <= '0;
        end else begin
            state    <= state_nxt;
            sec_cnt  <= cnt_nxt;
            ring_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = sec_cnt;
        idx_nxt   = ring_idx;
        if (force_idle) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_nxt = RINGING;
                        idx_nxt   = hit_idx;
                        cnt_nxt   = '0;
                    end
                end
                RINGING: begin
                    if (dismiss) begin
                        state_nxt = IDLE;
                    end else if (snooze) begin
                        state_nxt = SNOOZED;
                        cnt_nxt   = '0;
                    end else if (tick_1hz) begin
                        if (sec_cnt == RING_LAST) state_nxt = IDLE;
                        else                      cnt_nxt   = sec_cnt + CNT_W'(1);
                    end
                end
                SNOOZED: begin
                    if (dismiss) begin
                        state_nxt = IDLE;
                    end else if (tick_1hz) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            state_nxt = RINGING;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = sec_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        ringing   = (state == RINGING);
        fsm_state = state;
    end

    assign clock_hour   = now.hour;
    assign clock_minute = now.minute;
    assign clock_second = now.second;
    assign disp_hour    = mode_12h ? hour_12h(now.hour) : now.hour;
    assign pm           = (now.hour >= HMS_W'(12));
    assign alarm_armed  = armed;

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Bench for multi_alarm_clock_core: seconds-of-day model feeding an expected queue,
// per-cycle compare, plus directed vectors with hand-computed literal expectations.
module tb_multi_alarm_clock_core;
    import clock_pkg::*;

    localparam int CLK_HZ     = 4;
    localparam int NUM_ALARMS = 4;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_SEC = 2;
    localparam int IDX_W      = 2;
    localparam int EXP_W      = 36;

    logic             clk = 1'b0;
    logic             reset_en, run_en, time_wr, alarm_wr, alarm_on, snooze, dismiss, mode_12h;
    logic [5:0]       wr_hour, wr_minute, wr_second;
    logic [IDX_W-1:0] alarm_idx;
    logic [5:0]       clock_hour, clock_minute, clock_second, disp_hour;
    logic             pm, tick_1hz, hourly_chime, ringing;
    logic [IDX_W-1:0] ring_idx;
    logic [NUM_ALARMS-1:0] alarm_armed;
    state_t           fsm_state;

    int n_cmp = 0;
    int n_err = 0;

    // clock / reset
    always #5 clk = ~clk;

    multi_alarm_clock_core #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(NUM_ALARMS), .RING_SEC(RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC), .IDX_W(IDX_W)
    ) dut (
        .CLK_50(clk), .reset_en(reset_en), .run_en(run_en),
        .wr_hour(wr_hour), .wr_minute(wr_minute), .wr_second(wr_second),
        .time_wr(time_wr), .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_on(alarm_on),
        .snooze(snooze), .dismiss(dismiss), .mode_12h(mode_12h),
        .clock_hour(clock_hour), .clock_minute(clock_minute), .clock_second(clock_second),
        .disp_hour(disp_hour), .pm(pm), .tick_1hz(tick_1hz), .hourly_chime(hourly_chime),
        .ringing(ringing), .ring_idx(ring_idx), .alarm_armed(alarm_armed), .fsm_state(fsm_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: time as seconds of day, alarms as second-of-day values
    logic [EXP_W-1:0] exp_q[$];
    int m_sec, m_pre, m_mode, m_cnt, m_idx;
    bit m_tick, m_chime;
    int m_slot [NUM_ALARMS];
    bit m_armed [NUM_ALARMS];

    always @(posedge clk) begin
        int ws, hit_i, h, d;
        bit t_ok, a_ok, term, hit;
        logic [NUM_ALARMS-1:0] arm_v;
        logic [1:0] st;
        if (reset_en) begin
            m_sec = 0; m_pre = 0; m_mode = 0; m_cnt = 0; m_idx = 0; m_tick = 0; m_chime = 0;
            for (int i = 0; i < NUM_ALARMS; i++) begin m_slot[i] = 0; m_armed[i] = 0; end
        end else begin
            term = run_en && (m_pre == CLK_HZ - 1);
            ws   = int'(wr_hour) * 3600 + int'(wr_minute) * 60 + int'(wr_second);
            t_ok = time_wr && wr_hour <= 23 && wr_minute <= 59 && wr_second <= 59;
            a_ok = alarm_wr && wr_hour <= 23 && wr_minute <= 59 && wr_second <= 59;
            hit = 0; hit_i = 0;
            for (int i = 0; i < NUM_ALARMS; i++)
                if (!hit && m_armed[i] && m_slot[i] == m_sec) begin hit = 1; hit_i = i; end
            if (m_mode != 0 && a_ok && int'(alarm_idx) == m_idx) m_mode = 0;
            else if (m_mode == 0) begin
                if (m_tick && hit) begin m_mode = 1; m_idx = hit_i; m_cnt = 0; end
            end else if (m_mode == 1) begin
                if (dismiss) m_mode = 0;
                else if (snooze) begin m_mode = 2; m_cnt = 0; end
                else if (m_tick) begin m_cnt++; if (m_cnt == RING_SEC) m_mode = 0; end
            end else begin
                if (dismiss) m_mode = 0;
                else if (m_tick) begin m_cnt++; if (m_cnt == SNOOZE_SEC) begin m_mode = 1; m_cnt = 0; end end
            end
            if (t_ok) begin
                m_sec = ws; m_pre = 0; m_tick = 0; m_chime = 0;
            end else if (term) begin
                m_sec = (m_sec + 1) % 86400; m_pre = 0; m_tick = 1; m_chime = (m_sec % 3600 == 0);
            end else begin
                m_tick = 0; m_chime = 0;
                if (run_en) m_pre++;
            end
            if (a_ok) begin m_slot[alarm_idx] = ws; m_armed[alarm_idx] = alarm_on; end
        end
        h = m_sec / 3600;
        d = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
        for (int i = 0; i < NUM_ALARMS; i++) arm_v[i] = m_armed[i];
        st = (m_mode == 0) ? IDLE : (m_mode == 1) ? RINGING : SNOOZED;
        exp_q.push_back({6'(h), 6'((m_sec / 60) % 60), 6'(m_sec % 60), 6'(d), (h >= 12),
                         m_tick, m_chime, (m_mode == 1), 2'(m_idx), arm_v, st});
    end

    // scoreboard compare
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("clock_hour", clock_hour, e[35:30]);
            chk("clock_minute", clock_minute, e[29:24]);
            chk("clock_second", clock_second, e[23:18]);
            chk("disp_hour", disp_hour, e[17:12]);
            chk("pm", pm, e[11]);
            chk("tick_1hz", tick_1hz, e[10]);
            chk("hourly_chime", hourly_chime, e[9]);
            chk("ringing", ringing, e[8]);
            chk("ring_idx", ring_idx, e[7:6]);
            chk("alarm_armed", alarm_armed, e[5:2]);
            chk("fsm_state", fsm_state, e[1:0]);
        end
    end

    // drivers
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        wr_hour = 6'(h); wr_minute = 6'(m); wr_second = 6'(s); time_wr = 1'b1;
        cyc();
        time_wr = 1'b0;
    endtask

    task automatic set_alarm(input int idx, input int h, input int m, input int s, input bit on);
        wr_hour = 6'(h); wr_minute = 6'(m); wr_second = 6'(s);
        alarm_idx = 2'(idx); alarm_on = on; alarm_wr = 1'b1;
        cyc();
        alarm_wr = 1'b0;
    endtask

    task automatic wait_tick(input string nm);
        bit seen = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            cyc();
            if (tick_1hz === 1'b1) seen = 1;
        end
        chk(nm, seen, 1);
    endtask

    int bad_tbl [4][3] = '{'{25, 0, 0}, '{24, 0, 0}, '{0, 60, 0}, '{0, 0, 60}};

    initial begin
        reset_en = 1; run_en = 0; time_wr = 0; alarm_wr = 0; alarm_idx = 0; alarm_on = 0;
        snooze = 0; dismiss = 0; mode_12h = 1; wr_hour = 0; wr_minute = 0; wr_second = 0;
        cyc(); cyc();
        chk("rst clock_hour", clock_hour, 0);
        chk("rst disp_hour", disp_hour, 12);
        chk("rst pm", pm, 0);
        chk("rst alarm_armed", alarm_armed, 0);
        chk("rst ringing", ringing, 0);

        // rollover through midnight with chime on the second tick
        reset_en = 0; run_en = 1;
        set_time(23, 59, 58);
        repeat (3) cyc();
        chk("pre-tick tick_1hz", tick_1hz, 0);
        cyc();
        chk("tick1 tick_1hz", tick_1hz, 1);
        chk("tick1 second", clock_second, 59);
        chk("tick1 disp_hour", disp_hour, 11);
        chk("tick1 pm", pm, 1);
        chk("tick1 chime", hourly_chime, 0);
        repeat (4) cyc();
        chk("midnight tick", tick_1hz, 1);
        chk("midnight hour", clock_hour, 0);
        chk("midnight minute", clock_minute, 0);
        chk("midnight second", clock_second, 0);
        chk("midnight chime", hourly_chime, 1);
        chk("midnight disp_hour", disp_hour, 12);

        // two slots on the same time: lowest index rings
        set_alarm(1, 0, 0, 5, 1);
        set_alarm(2, 0, 0, 5, 1);
        set_time(0, 0, 4);
        chk("armed 1,2", alarm_armed, 4'b0110);
        wait_tick("wait match tick");
        chk("match second", clock_second, 5);
        chk("match cycle ringing", ringing, 0);
        cyc();
        chk("ring rises", ringing, 1);
        chk("ring_idx lowest", ring_idx, 1);

        // auto-stop after RING_SEC ticks
        wait_tick("ring tick1");
        wait_tick("ring tick2");
        wait_tick("ring tick3");
        chk("ring last tick", ringing, 1);
        cyc();
        chk("ring auto-stop", ringing, 0);

        // snooze, re-ring after SNOOZE_SEC ticks, then dismiss+snooze
        set_alarm(0, 0, 0, 10, 1);
        wait_tick("to :09");
        wait_tick("to :10");
        chk("slot0 second", clock_second, 10);
        cyc();
        chk("slot0 ringing", ringing, 1);
        chk("slot0 ring_idx", ring_idx, 0);
        snooze = 1; cyc(); snooze = 0;
        chk("snoozed ringing", ringing, 0);
        chk("snoozed state", fsm_state, SNOOZED);
        wait_tick("snooze tick1");
        chk("snooze tick1 ringing", ringing, 0);
        wait_tick("snooze tick2");
        cyc();
        chk("re-ring", ringing, 1);
        chk("re-ring idx", ring_idx, 0);
        dismiss = 1; snooze = 1; cyc(); dismiss = 0; snooze = 0;
        chk("dismiss wins ringing", ringing, 0);
        chk("dismiss wins state", fsm_state, IDLE);

        // out-of-range writes ignored while stopped
        run_en = 0;
        for (int i = 0; i < 4; i++) set_time(bad_tbl[i][0], bad_tbl[i][1], bad_tbl[i][2]);
        chk("bad wr hour", clock_hour, 0);
        chk("bad wr minute", clock_minute, 0);
        chk("bad wr second", clock_second, 12);

        // write on the terminal-count cycle wins, tick dropped
        run_en = 1;
        cyc();
        set_time(12, 34, 56);
        chk("term wr hour", clock_hour, 12);
        chk("term wr second", clock_second, 56);
        chk("term wr tick", tick_1hz, 0);
        chk("noon disp_hour", disp_hour, 12);
        chk("noon pm", pm, 1);
        wait_tick("after term wr");
        chk("after term wr second", clock_second, 57);

        // written time equal to an armed alarm never rings
        set_alarm(3, 12, 0, 0, 1);
        set_time(12, 0, 0);
        repeat (6) cyc();
        chk("written no ring", ringing, 0);
        set_time(13, 0, 0);
        chk("13h disp_hour", disp_hour, 1);
        chk("13h pm", pm, 1);
        mode_12h = 0; #1;
        chk("13h 24h disp", disp_hour, 13);
        mode_12h = 1;
        set_alarm(3, 12, 0, 0, 0);
        chk("disarm slot3", alarm_armed, 4'b0111);

        // reset while snoozed
        set_alarm(3, 7, 0, 0, 1);
        set_time(6, 59, 59);
        wait_tick("to 07:00");
        chk("07 chime", hourly_chime, 1);
        cyc();
        chk("07 ringing", ringing, 1);
        chk("07 ring_idx", ring_idx, 3);
        snooze = 1; cyc(); snooze = 0;
        chk("07 snoozed", fsm_state, SNOOZED);
        reset_en = 1; cyc(); reset_en = 0;
        chk("rst2 state", fsm_state, IDLE);
        chk("rst2 ringing", ringing, 0);
        chk("rst2 ring_idx", ring_idx, 0);
        chk("rst2 armed", alarm_armed, 0);
        chk("rst2 hour", clock_hour, 0);
        chk("rst2 second", clock_second, 0);
        chk("rst2 disp_hour", disp_hour, 12);
        chk("rst2 tick", tick_1hz, 0);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
